// File: rtl/cceip_job_sched.sv
// Job scheduler: queues job descriptors, launches them one at a time toward the
// inbound sequencer, tracks completion of both data paths and guards each wait phase.
module cceip_job_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          enable,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [63:0]                   job_size,
  output logic                          inbound_start,
  output logic [63:0]                   input_data_size,
  input  logic                          inbound_done,
  input  logic                          outbound_done,
  input  logic [CNT_W-1:0]              timeout_limit,
  input  logic                          err_clear,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [CNT_W-1:0]              jobs_done,
  output logic [CNT_W-1:0]              jobs_skipped,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_COMPLETE,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic              rst_q;
  logic [63:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [63:0]       head_size;
  logic              push, pop, launch, skip;
  logic              out_seen;
  logic [CNT_W-1:0]  wdog, wdog_inc;
  logic              wdog_hit;

  // Reset asserts immediately but releases on a clock edge, so the first
  // launch decision can happen on the second edge after release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_q <= 1'b0;
    else           rst_q <= 1'b1;
  end

  assign head_size     = mem[rd_ptr];
  assign job_ready     = rst_q && (fifo_level < DEPTH_L) && (state != S_ERROR);
  assign push          = job_valid && job_ready;
  assign pop           = (state == S_IDLE) && enable && (fifo_level != '0);
  assign launch        = pop && (head_size != '0);
  assign skip          = pop && (head_size == '0);
  assign inbound_start = (state == S_LAUNCH);
  assign busy          = (state != S_IDLE) && (state != S_ERROR);
  assign wdog_inc      = wdog + CNT_W'(1);
  assign wdog_hit      = (timeout_limit != '0) && (wdog_inc == timeout_limit);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (launch) state_nxt = S_LAUNCH;
      S_LAUNCH:   state_nxt = S_WAIT_IN;
      S_WAIT_IN: begin
        if (inbound_done && outbound_done) state_nxt = S_COMPLETE;
        else if (inbound_done)             state_nxt = S_WAIT_OUT;
        else if (wdog_hit)                 state_nxt = S_ERROR;
      end
      S_WAIT_OUT: begin
        if (outbound_done || out_seen) state_nxt = S_COMPLETE;
        else if (wdog_hit)             state_nxt = S_ERROR;
      end
      S_COMPLETE: state_nxt = S_IDLE;
      S_ERROR:    if (err_clear) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= job_size;
  end

  always_ff @(posedge ap_clk or negedge rst_q) begin
    if (!rst_q) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      input_data_size <= '0;
      timeout_err     <= 1'b0;
      jobs_done       <= '0;
      jobs_skipped    <= '0;
      out_seen        <= 1'b0;
      wdog            <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (launch)               input_data_size <= head_size;
      if (skip)                 jobs_skipped    <= jobs_skipped + CNT_W'(1);
      if (state == S_COMPLETE)  jobs_done       <= jobs_done + CNT_W'(1);
      if (state == S_ERROR && err_clear)
        timeout_err <= 1'b0;
      else if (state != S_ERROR && state_nxt == S_ERROR)
        timeout_err <= 1'b1;
      // An early outbound_done is remembered until the inbound side catches up.
      if (state == S_LAUNCH)
        out_seen <= 1'b0;
      else if (state == S_WAIT_IN && outbound_done)
        out_seen <= 1'b1;
      if (state_nxt != state && (state_nxt == S_WAIT_IN || state_nxt == S_WAIT_OUT))
        wdog <= '0;
      else if (state == S_WAIT_IN || state == S_WAIT_OUT)
        wdog <= wdog_inc;
    end
  end

endmodule

// File: tb/tb_cceip_job_sched.sv
// Self-checking bench for cceip_job_sched: directed scenarios, a FIFO fill table
// and a randomized run scored against a job-level queue model.
module tb_cceip_job_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        enable, job_valid, job_ready;
  logic [63:0] job_size, input_data_size;
  logic        inbound_start, inbound_done, outbound_done, err_clear;
  logic [31:0] timeout_limit, jobs_done, jobs_skipped;
  logic        busy, timeout_err;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  cceip_job_sched #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
    .job_valid(job_valid), .job_ready(job_ready), .job_size(job_size),
    .inbound_start(inbound_start), .input_data_size(input_data_size),
    .inbound_done(inbound_done), .outbound_done(outbound_done),
    .timeout_limit(timeout_limit), .err_clear(err_clear), .busy(busy),
    .timeout_err(timeout_err), .jobs_done(jobs_done),
    .jobs_skipped(jobs_skipped), .fifo_level(fifo_level)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic        valid;
    logic [63:0] size;
    logic        en;
    logic        exp_ready;
    logic [2:0]  exp_level;
    logic        exp_start;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    enable = 0; job_valid = 0; job_size = '0;
    inbound_done = 0; outbound_done = 0; err_clear = 0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic push(input logic [63:0] sz);
    @(negedge ap_clk);
    chk("push_ready", job_ready, 1);
    job_valid = 1; job_size = sz;
    @(negedge ap_clk);
    job_valid = 0;
  endtask

  // Returns the edge count at which the start pulse was observed.
  task automatic wait_start(output int at_edge);
    at_edge = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge ap_clk);
      if (inbound_start) begin
        at_edge = edge_cnt;
        break;
      end
    end
    if (at_edge < 0) chk("start_seen", 0, 1);
  endtask

  // Called at the launch cycle; pulses the done inputs k cycles later.
  task automatic serve(input int in_t, input int out_t);
    int m;
    m = (in_t > out_t) ? in_t : out_t;
    for (int k = 1; k <= m; k++) begin
      @(negedge ap_clk);
      inbound_done  = (k == in_t);
      outbound_done = (k == out_t);
    end
    @(negedge ap_clk);
    inbound_done = 0; outbound_done = 0;
  endtask

  vec_t vt[9];
  logic [63:0] exp_q[$];

  initial begin
    int e1, e2, cnt, zeros_total, nz_total, k, in_t, out_t, last_start;
    bit act, prev_start;
    logic [63:0] sz;

    ap_rst_n = 0; enable = 0; job_valid = 0; job_size = '0;
    inbound_done = 0; outbound_done = 0; err_clear = 0; timeout_limit = '0;
    #1;
    chk("rst_start", inbound_start, 0);
    chk("rst_size", input_data_size, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_done", jobs_done, 0);
    chk("rst_skip", jobs_skipped, 0);
    chk("rst_level", fifo_level, 0);
    do_reset();

    // Two jobs, long inbound and outbound latencies
    push(64); push(128);
    @(negedge ap_clk); enable = 1;
    wait_start(e1);
    chk("j40_size1", input_data_size, 64);
    serve(10, 15);
    wait_start(e2);
    chk("j40_size2", input_data_size, 128);
    serve(10, 15);
    repeat (3) @(negedge ap_clk);
    chk("j40_done", jobs_done, 2);
    chk("j40_busy", busy, 0);
    // stray done pulses in IDLE
    inbound_done = 1; outbound_done = 1;
    @(negedge ap_clk); inbound_done = 0; outbound_done = 0;
    repeat (2) @(negedge ap_clk);
    chk("idle_done_ignored", jobs_done, 2);
    chk("idle_busy", busy, 0);

    // FIFO fill with enable low, then release
    do_reset();
    vt[0] = '{1, 16, 0, 1, 0, 0};
    vt[1] = '{1, 32, 0, 1, 1, 0};
    vt[2] = '{1, 48, 0, 1, 2, 0};
    vt[3] = '{1, 64, 0, 1, 3, 0};
    vt[4] = '{1, 80, 0, 0, 4, 0};
    vt[5] = '{1, 80, 0, 0, 4, 0};
    vt[6] = '{1, 80, 1, 0, 4, 0};
    vt[7] = '{1, 80, 1, 1, 3, 1};
    vt[8] = '{0, 0,  0, 0, 4, 0};
    for (int i = 0; i < 9; i++) begin
      @(negedge ap_clk);
      chk($sformatf("tbl%0d_ready", i), job_ready, vt[i].exp_ready);
      chk($sformatf("tbl%0d_level", i), fifo_level, vt[i].exp_level);
      chk($sformatf("tbl%0d_start", i), inbound_start, vt[i].exp_start);
      job_valid = vt[i].valid; job_size = vt[i].size; enable = vt[i].en;
    end
    @(negedge ap_clk);
    chk("tbl_size", input_data_size, 16);
    chk("tbl_busy", busy, 1);

    // Zero-size job is discarded
    do_reset();
    push(0); push(8);
    @(negedge ap_clk); enable = 1;
    wait_start(e1);
    chk("skip_size", input_data_size, 8);
    chk("skip_cnt", jobs_skipped, 1);
    serve(1, 1);
    cnt = 0;
    repeat (10) begin @(negedge ap_clk); if (inbound_start) cnt++; end
    chk("skip_extra_starts", cnt, 0);
    chk("skip_done", jobs_done, 1);

    // Early and simultaneous outbound_done, minimum launch spacing
    do_reset();
    push(100); push(200); push(300);
    @(negedge ap_clk); enable = 1;
    wait_start(e1);
    chk("early_size", input_data_size, 100);
    serve(4, 2);
    repeat (2) @(negedge ap_clk);
    chk("early_done", jobs_done, 1);
    wait_start(e1);
    chk("same_size", input_data_size, 200);
    serve(1, 1);
    wait_start(e2);
    chk("launch_gap", e2 - e1, 4);
    chk("same_done", jobs_done, 2);
    serve(3, 3);
    repeat (2) @(negedge ap_clk);
    chk("third_done", jobs_done, 3);

    // Watchdog timeout and recovery
    do_reset();
    timeout_limit = 20;
    push(40); push(50);
    @(negedge ap_clk); enable = 1;
    wait_start(e1);
    repeat (20) @(negedge ap_clk);
    chk("wd_before", timeout_err, 0);
    chk("wd_before_busy", busy, 1);
    @(negedge ap_clk);
    chk("wd_err", timeout_err, 1);
    chk("wd_ready", job_ready, 0);
    chk("wd_busy", busy, 0);
    chk("wd_level", fifo_level, 1);
    inbound_done = 1; outbound_done = 1;
    @(negedge ap_clk); inbound_done = 0; outbound_done = 0;
    chk("wd_hold", timeout_err, 1);
    chk("wd_no_done", jobs_done, 0);
    err_clear = 1;
    @(negedge ap_clk); err_clear = 0;
    chk("wd_cleared", timeout_err, 0);
    e1 = edge_cnt;
    wait_start(e2);
    chk("wd_relaunch_gap", e2 - e1, 1);
    chk("wd_relaunch_size", input_data_size, 50);
    serve(1, 1);
    repeat (2) @(negedge ap_clk);
    chk("wd_done", jobs_done, 1);
    timeout_limit = 0;

    // Asynchronous reset in WAIT_OUT with jobs queued
    do_reset();
    push(10); push(20); push(30);
    @(negedge ap_clk); enable = 1;
    wait_start(e1);
    @(negedge ap_clk); inbound_done = 1;
    @(negedge ap_clk); inbound_done = 0;
    chk("ar_busy_pre", busy, 1);
    #2 ap_rst_n = 0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_level", fifo_level, 0);
    chk("ar_size", input_data_size, 0);
    chk("ar_start", inbound_start, 0);
    chk("ar_done", jobs_done, 0);
    chk("ar_terr", timeout_err, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1;
    cnt = 0;
    repeat (6) begin @(negedge ap_clk); if (inbound_start) cnt++; end
    chk("ar_no_start", cnt, 0);
    chk("ar_level_after", fifo_level, 0);

    // Randomized traffic against the job-queue model
    do_reset();
    exp_q.delete();
    zeros_total = 0; nz_total = 0; act = 0; k = 0; in_t = 0; out_t = 0;
    last_start = -100; prev_start = 0;
    for (int c = 0; c < 3500; c++) begin
      @(negedge ap_clk);
      if (inbound_start) begin
        chk("rnd_start_width", prev_start, 0);
        chk("rnd_start_gap", (edge_cnt - last_start) >= 4, 1);
        last_start = edge_cnt;
        while (exp_q.size() > 0 && exp_q[0] == 0) void'(exp_q.pop_front());
        if (exp_q.size() == 0) chk("rnd_start_unexpected", 1, 0);
        else chk("rnd_start_size", input_data_size, exp_q.pop_front());
        act = 1; k = 0;
        in_t = $urandom_range(1, 6); out_t = $urandom_range(1, 8);
      end else if (act) k++;
      prev_start = inbound_start;
      inbound_done  = act && (k == in_t);
      outbound_done = act && (k == out_t);
      if (act && k >= in_t && k >= out_t) act = 0;
      chk("rnd_ready_vs_level", job_ready, fifo_level < 4);
      if (c < 3000) begin
        enable = ($urandom % 10) < 7;
        job_valid = ($urandom % 3) == 0;
        sz = {$urandom, $urandom};
        job_size = (($urandom % 5) == 0) ? 64'd0 : sz;
      end else begin
        enable = 1; job_valid = 0;
      end
      if (job_valid && job_ready) begin
        exp_q.push_back(job_size);
        if (job_size == 0) zeros_total++; else nz_total++;
      end
    end
    chk("rnd_jobs_done", jobs_done, nz_total);
    chk("rnd_jobs_skipped", jobs_skipped, zeros_total);
    chk("rnd_level_end", fifo_level, 0);
    chk("rnd_busy_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
